// File: rtl/audio_out_pkg.sv
// audio_out_pkg: shared mode encodings and the signed saturation helper for the audio output stage
package audio_out_pkg;

    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_SD  = 1'b1;
    localparam int   SAT_W    = 48;

    function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v, input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (48'sd1 <<< (w - 1)) - 48'sd1;
        lo = -hi - 48'sd1;
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction

endpackage

// File: rtl/dc_blocker.sv
// dc_blocker: DC tracker, offset removal, power-of-2 gain and saturation back to offset-binary
module dc_blocker
    import audio_out_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DC_K   = 10,
    parameter int GAIN_W = 3
) (
    input  logic              clk,
    input  logic              RSTb,
    input  logic              tick,
    input  logic [IN_W-1:0]   x,
    input  logic              en,
    input  logic [GAIN_W-1:0] gain_shift,
    output logic [IN_W-1:0]   y,
    output logic              clip
);

    localparam int DW = IN_W + DC_K;
    localparam logic [IN_W-1:0] MID = {1'b1, {(IN_W-1){1'b0}}};

    logic [DW-1:0]           dc_q, dc_d;
    logic [IN_W-1:0]         y_q, y_d;
    logic                    clip_q, clip_d;
    logic [IN_W-1:0]         dc_hi, ref_v;
    logic signed [SAT_W-1:0] ac, sh, sat;

    // Leaky integrator update, AC extraction, gain and clamp; all state moves only on tick
    always_comb begin
        dc_hi  = dc_q[DW-1 -: IN_W];
        dc_d   = tick ? dc_q + {{DC_K{1'b0}}, x} - {{DC_K{1'b0}}, dc_hi} : dc_q;
        ref_v  = en ? dc_hi : MID;
        ac     = $signed({{(SAT_W-IN_W){1'b0}}, x}) - $signed({{(SAT_W-IN_W){1'b0}}, ref_v});
        sh     = ac <<< gain_shift;
        sat    = sat_signed(sh, IN_W);
        y_d    = tick ? sat[IN_W-1:0] ^ MID : y_q;
        clip_d = tick && (sat != sh);
    end

    // Sample registers; DC state starts at midscale so the first frames are quiet
    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            dc_q   <= {MID, {DC_K{1'b0}}};
            y_q    <= MID;
            clip_q <= 1'b0;
        end else begin
            dc_q   <= dc_d;
            y_q    <= y_d;
            clip_q <= clip_d;
        end
    end

    assign y    = y_q;
    assign clip = clip_q;

endmodule

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: frame-latched audio level driven out as classic PWM or 1st-order sigma-delta
module audio_pwm_out
    import audio_out_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int PWM_W  = 8,
    parameter int DC_K   = 10,
    parameter int GAIN_W = 3
) (
    input  logic              clk,
    input  logic              RSTb,
    input  logic [IN_W-1:0]   in_sample,
    input  logic              in_tick,
    input  logic              mode,
    input  logic              dc_block_en,
    input  logic [GAIN_W-1:0] gain_shift,
    output logic              pwm_out,
    output logic              frame_tick,
    output logic              clip
);

    localparam logic [PWM_W-1:0] HALF = {1'b1, {(PWM_W-1){1'b0}}};

    logic [IN_W-1:0]  pending;
    logic [PWM_W-1:0] cnt_q, cnt_d, active_q, active_d, acc_q, acc_d;
    logic             mode_q, mode_d, pwm_q, pwm_d, ft_q, ft_d;
    logic             boundary;
    logic [PWM_W:0]   sum;

    dc_blocker #(.IN_W(IN_W), .DC_K(DC_K), .GAIN_W(GAIN_W)) u_dc (
        .clk        (clk),
        .RSTb       (RSTb),
        .tick       (in_tick),
        .x          (in_sample),
        .en         (dc_block_en),
        .gain_shift (gain_shift),
        .y          (pending),
        .clip       (clip)
    );

    // Frame boundary latch plus PWM compare / sigma-delta carry generation
    always_comb begin
        boundary = &cnt_q;
        sum      = {1'b0, acc_q} + {1'b0, active_q};
        cnt_d    = cnt_q + PWM_W'(1);
        ft_d     = boundary;
        active_d = boundary ? PWM_W'(pending >> (IN_W - PWM_W)) : active_q;
        mode_d   = boundary ? mode : mode_q;
        acc_d    = (boundary && mode_q == MODE_PWM && mode == MODE_SD) ? '0 :
                   (mode_q == MODE_SD ? sum[PWM_W-1:0] : acc_q);
        pwm_d    = mode_q == MODE_SD ? sum[PWM_W] : (cnt_q < active_q);
    end

    // Output-stage state; reset restarts a midscale PWM frame from cnt 0
    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            active_q <= HALF;
            mode_q   <= MODE_PWM;
            pwm_q    <= 1'b0;
            ft_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            active_q <= active_d;
            mode_q   <= mode_d;
            pwm_q    <= pwm_d;
            ft_q     <= ft_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign frame_tick = ft_q;

endmodule
